// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter that multiplexes NUM_REQ requesters onto one FIFO write port.
// A grant ends on req_last, after MAX_BURST beats, or when the granted requester idles too long.
module async_fifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16,
  localparam int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_WIDTH-1:0]           fifo_wr_id,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int TO_W   = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [BEAT_W-1:0]   BEAT_LAST = BEAT_W'(MAX_BURST - 1);
  localparam logic [TO_W-1:0]     TO_LAST   = TO_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [ID_WIDTH:0]   N_EXT     = (ID_WIDTH + 1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] PTR_RST   = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic [ID_WIDTH-1:0] id, id_nxt;
  logic [ID_WIDTH-1:0] ptr, ptr_nxt;
  logic [ID_WIDTH-1:0] sel, off;
  logic [ID_WIDTH:0]   sel_sum;
  logic [NUM_REQ-1:0]  valid_rot;
  logic [BEAT_W-1:0]   beat_cnt, beat_nxt;
  logic [TO_W-1:0]     to_cnt, to_nxt;
  logic                err_nxt;
  logic                g_valid, g_last;

  // Rotate so bit 0 is the requester just after the last grant; lowest set bit wins.
  always_comb begin
    valid_rot = NUM_REQ'(({req_valid, req_valid} >> ptr) >> 1);
    off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (valid_rot[j]) off = ID_WIDTH'(j);
    end
    sel_sum = {1'b0, ptr} + {{ID_WIDTH{1'b0}}, 1'b1} + {1'b0, off};
    if (sel_sum >= N_EXT) sel_sum = sel_sum - N_EXT;
    sel = sel_sum[ID_WIDTH-1:0];
  end

  assign g_valid      = req_valid[id];
  assign g_last       = req_last[id];
  assign busy         = (state == XFER);
  assign fifo_wr_en   = busy & g_valid & ~fifo_full;
  assign req_ready    = grant & {NUM_REQ{~fifo_full}};
  assign fifo_wr_data = req_data[id*DATA_WIDTH +: DATA_WIDTH];
  assign fifo_wr_id   = id;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    id_nxt    = id;
    ptr_nxt   = ptr;
    beat_nxt  = beat_cnt;
    to_nxt    = to_cnt;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt = XFER;
          grant_nxt = NUM_REQ'(1) << sel;
          id_nxt    = sel;
          beat_nxt  = '0;
          to_nxt    = '0;
        end
      end
      XFER: begin
        if (fifo_wr_en) begin
          beat_nxt = beat_cnt + 1'b1;
          to_nxt   = '0;
          if (g_last || (beat_cnt == BEAT_LAST)) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            ptr_nxt   = id;
          end
        end else if (!fifo_full && !g_valid && (IDLE_TIMEOUT != 0)) begin
          // Stalled requester: only non-full idle cycles count toward revocation.
          to_nxt = to_cnt + 1'b1;
          if (to_cnt == TO_LAST) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
            grant_nxt = '0;
            ptr_nxt   = id;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      id          <= '0;
      ptr         <= PTR_RST;
      beat_cnt    <= '0;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      id          <= id_nxt;
      ptr         <= ptr_nxt;
      beat_cnt    <= beat_nxt;
      to_cnt      <= to_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Bench for async_fifo_wr_arbiter: directed scenarios plus a randomized multi-requester run,
// all compared cycle by cycle against an integer-level arbitration model.
module tb_async_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;
  localparam int TO = 16;
  localparam int CW = 2*N + 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic [1:0]    fifo_wr_id;
  logic [N-1:0]  grant;
  logic          busy;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;

  // Model state: granted index (-1 when idle), last-grant pointer, beats and idle cycles in this grant.
  int m_cur, m_ptr, m_beats, m_idle;
  bit m_err;

  async_fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_id(fifo_wr_id),
    .grant(grant), .busy(busy), .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    m_cur = -1; m_ptr = N - 1; m_beats = 0; m_idle = 0; m_err = 0;
  endfunction

  function automatic bit m_wr();
    return (m_cur >= 0) && req_valid[m_cur] && !fifo_full;
  endfunction

  function automatic logic [CW-1:0] m_ctrl();
    logic [N-1:0] g = '0;
    logic [N-1:0] r = '0;
    logic [1:0]   i = '0;
    if (m_cur >= 0) begin
      g[m_cur] = 1'b1;
      if (!fifo_full) r[m_cur] = 1'b1;
      i = 2'(m_cur);
    end
    return {g, r, m_wr(), m_cur >= 0, m_err, i};
  endfunction

  function automatic logic [CW-1:0] dut_ctrl();
    return {grant, req_ready, fifo_wr_en, busy, err_timeout, (m_cur >= 0) ? fifo_wr_id : 2'b00};
  endfunction

  function automatic logic [DW-1:0] m_data();
    return req_data[m_cur*DW +: DW];
  endfunction

  // One clock of the arbitration rules, evaluated on the inputs seen during that cycle.
  function automatic void model_update();
    bit wr = m_wr();
    m_err = 0;
    if (m_cur < 0) begin
      for (int k = 1; k <= N; k++) begin
        int i = (m_ptr + k) % N;
        if (req_valid[i]) begin
          m_cur = i; m_beats = 0; m_idle = 0;
          break;
        end
      end
    end else if (wr) begin
      m_beats++; m_idle = 0;
      if (req_last[m_cur] || m_beats == MB) begin m_ptr = m_cur; m_cur = -1; end
    end else if (!fifo_full && !req_valid[m_cur]) begin
      m_idle++;
      if (m_idle == TO) begin m_err = 1; m_ptr = m_cur; m_cur = -1; end
    end
  endfunction

  function automatic int oh_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    advance();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fifo_full = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'($urandom) | 4'b0001; req_last = 4'($urandom); req_data = $urandom;
      @(negedge clk);
      checks++;
      if (dut_ctrl() !== m_ctrl()) begin
        errors++; $display("FAIL reset_state cyc %0d: got %b expected %b", c, dut_ctrl(), m_ctrl());
      end
    end
    req_valid = '0; req_last = '0;
    rst_n = 1'b1;
    advance();
  endtask

  task automatic test_single_packet();
    int k = 0, mw = 0, dw = 0;
    bit acc;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = '0; req_last = '0; req_data = '0;
      req_valid[0] = (k < 3);
      req_data[0 +: DW] = 8'(8'hA0 + k);
      req_last[0] = (k == 2);
      @(negedge clk);
      checks++;
      if (dut_ctrl() !== m_ctrl()) begin
        errors++; $display("FAIL single_ctrl cyc %0d: got %b expected %b", c, dut_ctrl(), m_ctrl());
      end
      if (m_wr()) begin
        checks++;
        if (fifo_wr_data !== 8'(8'hA0 + mw)) begin
          errors++; $display("FAIL single_data cyc %0d: got %h expected %h", c, fifo_wr_data, 8'(8'hA0 + mw));
        end
        mw++;
      end
      if (fifo_wr_en) dw++;
      acc = req_ready[0] && req_valid[0];
      advance();
      if (acc) k++;
    end
    @(negedge clk);
    checks++;
    if (dw !== 3) begin errors++; $display("FAIL single_count: got %0d writes expected 3", dw); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int gseq[$];
    int wcnt[$];
    int gaps[$];
    int idle_run = 0;
    logic prev_busy = 1'b0;
    do_reset();
    req_valid = '1; req_last = '0;
    for (int c = 0; c < 60; c++) begin
      req_data = $urandom;
      @(negedge clk);
      checks++;
      if (dut_ctrl() !== m_ctrl()) begin
        errors++; $display("FAIL rr_ctrl cyc %0d: got %b expected %b", c, dut_ctrl(), m_ctrl());
      end
      if (m_wr()) begin
        checks++;
        if (fifo_wr_data !== m_data()) begin
          errors++; $display("FAIL rr_data cyc %0d: got %h expected %h", c, fifo_wr_data, m_data());
        end
      end
      if (busy && !prev_busy) begin
        if (gseq.size() > 0) gaps.push_back(idle_run);
        gseq.push_back(oh_idx(grant));
        wcnt.push_back(0);
        idle_run = 0;
      end
      if (!busy) idle_run++;
      if (fifo_wr_en && wcnt.size() > 0) wcnt[wcnt.size()-1]++;
      prev_busy = busy;
      advance();
    end
    checks++;
    if (gseq.size() < 6) begin
      errors++; $display("FAIL rr_grant_count: got %0d grants expected at least 6", gseq.size());
    end else begin
      for (int g = 0; g < 6; g++) begin
        checks++;
        if (gseq[g] != g % N) begin
          errors++; $display("FAIL rr_order grant %0d: got %0d expected %0d", g, gseq[g], g % N);
        end
      end
      for (int g = 0; g < 5; g++) begin
        checks++;
        if (wcnt[g] != MB || gaps[g] != 1) begin
          errors++; $display("FAIL rr_burst grant %0d: got %0d writes gap %0d expected %0d writes gap 1", g, wcnt[g], gaps[g], MB);
        end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_full_stall();
    logic [DW-1:0] pkt[6];
    logic [DW-1:0] got[$];
    int k = 0, full_left = 0, full_cyc = 0, errs = 0;
    bit acc;
    do_reset();
    foreach (pkt[i]) pkt[i] = DW'($urandom);
    for (int c = 0; c < 20; c++) begin
      req_valid = '0; req_last = '0; req_data = $urandom;
      req_valid[2] = (k < 6);
      req_data[2*DW +: DW] = pkt[(k < 6) ? k : 5];
      req_last[2] = (k == 5);
      fifo_full = (full_left > 0);
      @(negedge clk);
      checks++;
      if (dut_ctrl() !== m_ctrl()) begin
        errors++; $display("FAIL full_ctrl cyc %0d: got %b expected %b", c, dut_ctrl(), m_ctrl());
      end
      if (m_wr()) begin
        checks++;
        if (fifo_wr_data !== m_data()) begin
          errors++; $display("FAIL full_data cyc %0d: got %h expected %h", c, fifo_wr_data, m_data());
        end
      end
      if (fifo_full) begin
        full_cyc++;
        checks++;
        if ({req_ready, fifo_wr_en} !== 5'b0) begin
          errors++; $display("FAIL full_gating cyc %0d: got ready %b wr_en %b expected 0", c, req_ready, fifo_wr_en);
        end
      end
      if (err_timeout) errs++;
      if (fifo_wr_en) got.push_back(fifo_wr_data);
      acc = req_ready[2] && req_valid[2];
      advance();
      if (fifo_full) full_left--;
      if (acc) begin
        k++;
        if (k == 2) full_left = 5;
      end
    end
    fifo_full = 1'b0;
    checks++;
    if (got.size() != 6 || full_cyc != 5 || errs != 0) begin
      errors++; $display("FAIL full_summary: got %0d beats %0d full cycles %0d timeouts expected 6 5 0", got.size(), full_cyc, errs);
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== pkt[i]) begin
        errors++; $display("FAIL full_order beat %0d: got %h expected %h", i, got[i], pkt[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int k1 = 0, errs = 0, err_cyc = -1, last_w = -1, r1w = 0, next_g = -1;
    logic prev_busy = 1'b0;
    bit acc;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      req_valid = '0; req_last = '0; req_data = $urandom;
      req_valid[1] = (k1 < 2);
      req_valid[2] = 1'b1;
      req_last[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (dut_ctrl() !== m_ctrl()) begin
        errors++; $display("FAIL timeout_ctrl cyc %0d: got %b expected %b", c, dut_ctrl(), m_ctrl());
      end
      if (m_wr()) begin
        checks++;
        if (fifo_wr_data !== m_data()) begin
          errors++; $display("FAIL timeout_data cyc %0d: got %h expected %h", c, fifo_wr_data, m_data());
        end
      end
      if (fifo_wr_en && fifo_wr_id == 2'd1) begin r1w++; last_w = c; end
      if (err_timeout) begin errs++; err_cyc = c; end
      if (busy && !prev_busy && errs > 0 && next_g < 0) next_g = oh_idx(grant);
      prev_busy = busy;
      acc = req_ready[1] && req_valid[1];
      advance();
      if (acc) k1++;
    end
    req_valid = '0;
    checks++;
    if (errs != 1 || r1w != 2) begin
      errors++; $display("FAIL timeout_counts: got %0d pulses %0d req1 beats expected 1 2", errs, r1w);
    end
    checks++;
    if (err_cyc - last_w != TO + 1) begin
      errors++; $display("FAIL timeout_delay: got %0d cycles expected %0d", err_cyc - last_w, TO + 1);
    end
    checks++;
    if (next_g != 2) begin
      errors++; $display("FAIL timeout_next_grant: got %0d expected 2", next_g);
    end
  endtask

  task automatic test_reset_mid_burst();
    int dw = 0, c = 0;
    do_reset();
    req_valid = 4'b1000; req_last = '0;
    while (dw < 3 && c < 12) begin
      req_data = $urandom;
      @(negedge clk);
      checks++;
      if (dut_ctrl() !== m_ctrl()) begin
        errors++; $display("FAIL rstmid_ctrl cyc %0d: got %b expected %b", c, dut_ctrl(), m_ctrl());
      end
      if (fifo_wr_en) dw++;
      advance();
      c++;
    end
    checks++;
    if (dw != 3) begin errors++; $display("FAIL rstmid_setup: got %0d beats expected 3", dw); end
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, busy, fifo_wr_en, req_ready} !== '0) begin
      errors++; $display("FAIL rstmid_async_drop: got grant %b busy %b wr_en %b ready %b expected 0", grant, busy, fifo_wr_en, req_ready);
    end
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({grant, busy, fifo_wr_en} !== '0) begin
      errors++; $display("FAIL rstmid_held: got grant %b busy %b wr_en %b expected 0", grant, busy, fifo_wr_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    advance();
    for (int i = 0; i < 4; i++) begin
      req_data = $urandom;
      @(negedge clk);
      checks++;
      if (dut_ctrl() !== m_ctrl()) begin
        errors++; $display("FAIL rstmid_after cyc %0d: got %b expected %b", i, dut_ctrl(), m_ctrl());
      end
      if (i == 0) begin
        checks++;
        if (grant !== 4'b0001) begin
          errors++; $display("FAIL rstmid_first_grant: got %b expected 0001", grant);
        end
      end
      advance();
    end
    req_valid = '0;
  endtask

  task automatic test_random_traffic();
    logic [9:0] fq[$];
    logic [9:0] e;
    int sent[N], pkt_left[N], gap[N], exp_seq[N];
    int popped = 0, c = 0;
    logic wr;
    logic [DW-1:0] wd;
    logic [1:0] wid;
    logic [N-1:0] acc;
    do_reset();
    for (int i = 0; i < N; i++) begin sent[i] = 0; pkt_left[i] = 0; gap[i] = 0; exp_seq[i] = 0; end
    while (popped < 200 && c < 4000) begin
      for (int i = 0; i < N; i++) begin
        if (pkt_left[i] == 0 && sent[i] < 50) begin
          pkt_left[i] = $urandom_range(1, 10);
          if (pkt_left[i] > 50 - sent[i]) pkt_left[i] = 50 - sent[i];
        end
        req_valid[i] = (sent[i] < 50) && (gap[i] == 0);
        req_data[i*DW +: DW] = {2'(i), 6'(sent[i])};
        req_last[i] = (pkt_left[i] == 1);
      end
      fifo_full = (fq.size() >= 16);
      @(negedge clk);
      checks++;
      if (dut_ctrl() !== m_ctrl()) begin
        errors++; $display("FAIL rand_ctrl cyc %0d: got %b expected %b", c, dut_ctrl(), m_ctrl());
      end
      if (m_wr()) begin
        checks++;
        if (fifo_wr_data !== m_data()) begin
          errors++; $display("FAIL rand_data cyc %0d: got %h expected %h", c, fifo_wr_data, m_data());
        end
      end
      wr = fifo_wr_en; wd = fifo_wr_data; wid = fifo_wr_id;
      acc = req_ready & req_valid;
      if (wr && fq.size() >= 16) begin
        checks++; errors++;
        $display("FAIL rand_overflow cyc %0d: got write with %0d entries expected none", c, fq.size());
      end
      advance();
      if (wr) fq.push_back({wid, wd});
      if (fq.size() > 0 && $urandom_range(0, 3) != 0) begin
        e = fq.pop_front();
        checks++;
        if (e[7:0] !== {e[9:8], 6'(exp_seq[e[9:8]])}) begin
          errors++; $display("FAIL rand_read_order id %0d: got %h expected %h", e[9:8], e[7:0], {e[9:8], 6'(exp_seq[e[9:8]])});
        end
        exp_seq[e[9:8]]++;
        popped++;
      end
      for (int i = 0; i < N; i++) begin
        if (gap[i] > 0) gap[i]--;
        if (acc[i]) begin
          sent[i]++;
          pkt_left[i]--;
          if (pkt_left[i] == 0) gap[i] = $urandom_range(0, 3);
        end
      end
      c++;
    end
    req_valid = '0; fifo_full = 1'b0;
    checks++;
    if (popped != 200) begin errors++; $display("FAIL rand_total: got %0d beats expected 200", popped); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (exp_seq[i] != 50) begin
        errors++; $display("FAIL rand_per_id id %0d: got %0d beats expected 50", i, exp_seq[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    model_reset();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_full_stall();
    test_timeout();
    test_reset_mid_burst();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
